// File: rtl/iopad_ctrl_pkg.sv
// rtl/iopad_ctrl_pkg.sv - shared types and defaults for the iopad direction sequencer
// Contents: FSM state enum, arbitration priority encoding (WR=0, RD=1),
//   default parameter values and a small max helper for counter sizing.
package iopad_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_TURN   = 3'd2,
    ST_SWAIT  = 3'd3,
    ST_SAMPLE = 3'd4
  } state_e;

  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } prio_e;

  localparam int DW_DEF         = 8;
  localparam int TURN_CYC_DEF   = 2;
  localparam int SAMPLE_DLY_DEF = 1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/iopad_rr_arb.sv
// rtl/iopad_rr_arb.sv - two-requester round-robin arbiter (write vs read)
// Ports:
//   wr_req, rd_req : requests
//   prio           : side that wins a tie
//   gnt_wr, gnt_rd : one-hot (or zero) grant
//   prio_nxt       : priority after this decision; a grant hands priority
//                    to the other side, no grant leaves it unchanged
module iopad_rr_arb
  import iopad_ctrl_pkg::*;
(
  input  logic  wr_req,
  input  logic  rd_req,
  input  prio_e prio,
  output logic  gnt_wr,
  output logic  gnt_rd,
  output prio_e prio_nxt
);

  always_comb begin
    gnt_wr   = wr_req && (!rd_req || (prio == PRIO_WR));
    gnt_rd   = rd_req && (!wr_req || (prio == PRIO_RD));
    prio_nxt = prio;
    if (gnt_wr) begin
      prio_nxt = PRIO_RD;
    end else if (gnt_rd) begin
      prio_nxt = PRIO_WR;
    end
  end

endmodule

// File: rtl/iopad_dir_ctrl.sv
// rtl/iopad_dir_ctrl.sv - direction sequencer for a bidirectional iopad bank
// Shares one DW-wide pad bank between a write requester (drives the pad) and a
// read requester (samples the pad), with bus turnaround after writes and
// round-robin arbitration. All pad controls and handshakes are registered.
// Optional build macro: IOPAD_DRV_MASK_EN adds wr_mask, a per-bit drive enable
//   held with wr_data; released bits drive 0 on pad_dout.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   wr_req/wr_data/wr_ack : write request, data, 1-cycle accept pulse
//   rd_req/rd_valid/rd_data : read request, 1-cycle valid pulse, captured data
//   pad_din               : pad input value
//   pad_dout/pad_dout_en  : pad output value and per-bit output enable
//   busy                  : sequencer not idle
module iopad_dir_ctrl
  import iopad_ctrl_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int TURN_CYC   = TURN_CYC_DEF,
  parameter int SAMPLE_DLY = SAMPLE_DLY_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req,
  input  logic [DW-1:0] wr_data,
`ifdef IOPAD_DRV_MASK_EN
  input  logic [DW-1:0] wr_mask,
`endif
  output logic          wr_ack,
  input  logic          rd_req,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic [DW-1:0] pad_din,
  output logic [DW-1:0] pad_dout,
  output logic [DW-1:0] pad_dout_en,
  output logic          busy
);

  localparam int CW = $clog2(max2(TURN_CYC, SAMPLE_DLY) + 1);

  state_e        state_q, state_d;
  prio_e         prio_q, prio_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [DW-1:0] pad_dout_q, pad_dout_d;
  logic [DW-1:0] pad_dout_en_q, pad_dout_en_d;
  logic          wr_ack_q, wr_ack_d;
  logic          rd_valid_q, rd_valid_d;

  logic          gnt_wr, gnt_rd;
  prio_e         prio_nxt;
  logic [DW-1:0] drv_en;
  logic          wr_go, rd_go;

`ifdef IOPAD_DRV_MASK_EN
  assign drv_en = wr_mask;
`else
  assign drv_en = '1;
`endif

  iopad_rr_arb u_arb (
    .wr_req   (wr_req),
    .rd_req   (rd_req),
    .prio     (prio_q),
    .gnt_wr   (gnt_wr),
    .gnt_rd   (gnt_rd),
    .prio_nxt (prio_nxt)
  );

  // Outputs are computed for the state being entered, so the registered pad
  // controls line up with the state they belong to.
  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    cnt_d         = cnt_q;
    rd_data_d     = rd_data_q;
    pad_dout_d    = '0;
    pad_dout_en_d = '0;
    wr_ack_d      = 1'b0;
    rd_valid_d    = 1'b0;
    wr_go         = 1'b0;
    rd_go         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_wr) begin
          wr_go = 1'b1;
        end else if (gnt_rd) begin
          rd_go = 1'b1;
        end
      end
      ST_DRIVE: begin
        // wr_req still high in the ack cycle is the next word; keep driving
        // without turnaround unless the read side wins the tie.
        if (gnt_wr) begin
          wr_go = 1'b1;
        end else begin
          state_d = ST_TURN;
          cnt_d   = CW'(TURN_CYC);
        end
      end
      ST_TURN: begin
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_SWAIT: begin
        if (cnt_q == CW'(1)) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_SAMPLE: begin
        rd_data_d  = pad_din;
        rd_valid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (wr_go) begin
      state_d       = ST_DRIVE;
      prio_d        = prio_nxt;
      wr_ack_d      = 1'b1;
      pad_dout_en_d = drv_en;
      pad_dout_d    = wr_data & drv_en;
    end
    if (rd_go) begin
      state_d = ST_SWAIT;
      prio_d  = prio_nxt;
      cnt_d   = CW'(SAMPLE_DLY);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      prio_q        <= PRIO_WR;
      cnt_q         <= '0;
      rd_data_q     <= '0;
      pad_dout_q    <= '0;
      pad_dout_en_q <= '0;
      wr_ack_q      <= 1'b0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      cnt_q         <= cnt_d;
      rd_data_q     <= rd_data_d;
      pad_dout_q    <= pad_dout_d;
      pad_dout_en_q <= pad_dout_en_d;
      wr_ack_q      <= wr_ack_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  assign wr_ack      = wr_ack_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign pad_dout    = pad_dout_q;
  assign pad_dout_en = pad_dout_en_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
